// File: rtl/sync_arith_unit_seq.sv
// Signed M-bit ALU: single-cycle add/compare, iterative shift-add multiply and restoring divide.
// Optional SYNC_ARITH_STICKY_ERR_EN makes o_status[3] sticky until i_reset.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | multiply/divide iterating, one step per cycle
// DONE  | result strobe cycle, back to IDLE next
module sync_arith_unit_seq #(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_op,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  output logic         o_valid,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  localparam int CW = $clog2(M + 1);
  localparam logic [M-1:0]   ONE_M  = 1;
  localparam logic [2*M-1:0] ONE_2M = 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-1:0] prod_q, prod_d;
  logic [M-1:0]   mag_a_q, mag_a_d;
  logic [M-1:0]   mag_b_q, mag_b_d;
  logic           is_div_q, is_div_d;
  logic           sign_q, sign_d;
  logic           valid_q, valid_d;
  logic [M-1:0]   result_q, result_d;
  logic [3:0]     status_q, status_d;

  logic           op_hi;
  logic [M-1:0]   mag_a_in, mag_b_in;
  logic [M-1:0]   add_sum;
  logic           add_ov;
  logic [M-1:0]   cmp_res;

  if (N > 2) begin : g_wide_op
    assign op_hi = |i_op[N-1:2];
  end else begin : g_narrow_op
    assign op_hi = 1'b0;
  end

  assign mag_a_in = i_arg_A[M-1] ? (~i_arg_A + ONE_M) : i_arg_A;
  assign mag_b_in = i_arg_B[M-1] ? (~i_arg_B + ONE_M) : i_arg_B;
  assign add_sum  = i_arg_A + i_arg_B;
  assign add_ov   = (i_arg_A[M-1] == i_arg_B[M-1]) && (add_sum[M-1] != i_arg_A[M-1]);

  always_comb begin
    cmp_res    = '0;
    cmp_res[0] = $signed(i_arg_A) < $signed(i_arg_B);
    cmp_res[1] = (i_arg_A == i_arg_B);
  end

  // One shared adder: accumulate for multiply, trial subtract for divide.
  // prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  logic [M:0]     r_sh;
  logic [M+1:0]   alu_x, alu_y, alu_sum;
  logic           alu_cin;
  logic [M-1:0]   r_new;
  logic [2*M-1:0] prod_step;

  always_comb begin
    r_sh = prod_q[2*M-1:M-1];
    if (is_div_q) begin
      alu_x   = {1'b0, r_sh};
      alu_y   = ~{2'b00, mag_b_q};
      alu_cin = 1'b1;
    end else begin
      alu_x   = {2'b00, prod_q[2*M-1:M]};
      alu_y   = prod_q[0] ? {2'b00, mag_a_q} : '0;
      alu_cin = 1'b0;
    end
    alu_sum = alu_x + alu_y + {{(M+1){1'b0}}, alu_cin};
    r_new   = alu_sum[M+1] ? r_sh[M-1:0] : alu_sum[M-1:0];
    if (is_div_q) prod_step = {r_new, prod_q[M-2:0], ~alu_sum[M+1]};
    else          prod_step = {alu_sum[M:0], prod_q[M-1:1]};
  end

  logic [2*M-1:0] prod_signed;
  logic [M-1:0]   quot_signed;
  logic           mul_ov, div_ov;

  always_comb begin
    prod_signed = sign_q ? (~prod_step + ONE_2M) : prod_step;
    quot_signed = sign_q ? (~prod_step[M-1:0] + ONE_M) : prod_step[M-1:0];
    mul_ov      = !((&prod_signed[2*M-1:M-1]) || !(|prod_signed[2*M-1:M-1]));
    // Only a positive quotient of 2^(M-1) is unrepresentable (-2^(M-1) / -1).
    div_ov      = !sign_q && prod_step[M-1];
  end

  logic         fin, fin_ov, fin_err, err_keep;
  logic [M-1:0] fin_res;

  always_comb begin
`ifdef SYNC_ARITH_STICKY_ERR_EN
    err_keep = status_q[3];
`else
    err_keep = 1'b0;
`endif
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    valid_d  = 1'b0;
    result_d = result_q;
    status_d = status_q;
    fin      = 1'b0;
    fin_res  = '0;
    fin_ov   = 1'b0;
    fin_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          sign_d = i_arg_A[M-1] ^ i_arg_B[M-1];
          cnt_d  = CW'(M);
          if (op_hi) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            case (i_op[1:0])
              2'd0: begin
                fin     = 1'b1;
                fin_res = add_sum;
                fin_ov  = add_ov;
              end
              2'd1: begin
                fin     = 1'b1;
                fin_res = cmp_res;
              end
              2'd2: begin
                state_d  = BUSY;
                is_div_d = 1'b0;
                mag_a_d  = mag_a_in;
                prod_d   = {{M{1'b0}}, mag_b_in};
              end
              default: begin
                if (i_arg_B == '0) begin
                  fin     = 1'b1;
                  fin_err = 1'b1;
                end else begin
                  state_d  = BUSY;
                  is_div_d = 1'b1;
                  mag_b_d  = mag_b_in;
                  prod_d   = {{M{1'b0}}, mag_a_in};
                end
              end
            endcase
          end
        end
      end
      BUSY: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          fin_res = is_div_q ? quot_signed : prod_signed[M-1:0];
          fin_ov  = is_div_q ? div_ov : mul_ov;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d  = DONE;
      valid_d  = 1'b1;
      result_d = fin_res;
      status_d = {fin_err | err_keep, fin_res[M-1], fin_res == '0, fin_ov};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      status_q <= 4'b0010;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_sync_arith_unit_seq.sv
// Bench for sync_arith_unit_seq (M=4, N=2): vector table plus scoreboard queue,
// with hand-written sequences for ignored requests and mid-operation reset.
module tb_sync_arith_unit_seq;

`ifdef SYNC_ARITH_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [1:0] i_op = '0;
  logic [3:0] i_a = '0;
  logic [3:0] i_b = '0;
  logic       o_ready, o_valid;
  logic [3:0] o_result, o_status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  bit sticky_seen = 1'b0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] st;
    int         lat;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic [3:0] st;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_arith_unit_seq #(.N(2), .M(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_arg_A (i_a),
    .i_arg_B (i_b),
    .o_valid (o_valid),
    .o_result(o_result),
    .o_status(o_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] adj(input logic [3:0] st);
    return st | ((STICKY && sticky_seen) ? 4'b1000 : 4'b0000);
  endfunction

  always @(negedge clk) begin
    if (o_valid) begin
      exp_t e;
      n_valid++;
      if (sb.size() == 0) begin
        check("o_valid_without_request", 32'(o_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, 32'(o_result), 32'(e.res));
        check({e.name, "_status"}, 32'(o_status), 32'(e.st));
        check({e.name, "_latency"}, cyc - e.acc, e.lat);
      end
    end
  end

  task automatic push_exp(input logic [3:0] res, input logic [3:0] st, input int lat, input string name);
    exp_t e;
    e.res  = res;
    e.st   = adj(st);
    e.lat  = lat;
    e.acc  = cyc;
    e.name = name;
    sb.push_back(e);
    if (st[3]) sticky_seen = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_before_accept"}, 32'(o_ready), 32'(1));
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] res, input logic [3:0] st, input int lat,
                        input string name);
    int n;
    wait_ready(name);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    push_exp(res, st, lat, name);
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({name, "_ready_low_cycles"}, n, lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sticky_seen = 1'b0;
  endtask

  initial begin
    int n0;
    vecs[0]  = '{2'd0, 4'b0111, 4'b0001, 4'b1000, 4'b0101, 1};
    vecs[1]  = '{2'd1, 4'b1100, 4'b0011, 4'b0001, 4'b0000, 1};
    vecs[2]  = '{2'd1, 4'b1101, 4'b1101, 4'b0010, 4'b0000, 1};
    vecs[3]  = '{2'd2, 4'b0011, 4'b1110, 4'b1010, 4'b0100, 5};
    vecs[4]  = '{2'd2, 4'b0100, 4'b0100, 4'b0000, 4'b0011, 5};
    vecs[5]  = '{2'd3, 4'b1001, 4'b0010, 4'b1101, 4'b0100, 5};
    vecs[6]  = '{2'd3, 4'b1000, 4'b1111, 4'b1000, 4'b0101, 5};
    vecs[7]  = '{2'd3, 4'b0101, 4'b0000, 4'b0000, 4'b1010, 1};
    vecs[8]  = '{2'd0, 4'b1000, 4'b1000, 4'b0000, 4'b0011, 1};
    vecs[9]  = '{2'd0, 4'b0011, 4'b1100, 4'b1111, 4'b0100, 1};
    vecs[10] = '{2'd1, 4'b0111, 4'b1000, 4'b0000, 4'b0010, 1};
    vecs[11] = '{2'd2, 4'b1000, 4'b0001, 4'b1000, 4'b0100, 5};
    vecs[12] = '{2'd2, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 5};
    vecs[13] = '{2'd2, 4'b0111, 4'b0111, 4'b0001, 4'b0001, 5};
    vecs[14] = '{2'd3, 4'b0111, 4'b1110, 4'b1101, 4'b0100, 5};
    vecs[15] = '{2'd3, 4'b1000, 4'b0001, 4'b1000, 4'b0100, 5};
    vecs[16] = '{2'd3, 4'b0000, 4'b0011, 4'b0000, 4'b0010, 5};
    vecs[17] = '{2'd3, 4'b0110, 4'b0011, 4'b0010, 4'b0000, 5};

    @(negedge clk);
    do_reset();
    check("reset_ready", 32'(o_ready), 32'(1));
    check("reset_valid", 32'(o_valid), 32'(0));
    check("reset_result", 32'(o_result), 32'(0));
    check("reset_status", 32'(o_status), 32'(4'b0010));

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].st, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Requests while busy must be dropped without disturbing the multiply.
    wait_ready("ignored");
    n0      = n_valid;
    i_valid = 1'b1;
    i_op    = 2'd2;
    i_a     = 4'b0011;
    i_b     = 4'b1110;
    push_exp(4'b1010, 4'b0100, 5, "ignored_mul");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid) break;
      i_valid = 1'b1;
      i_op    = 2'($urandom_range(0, 3));
      i_a     = 4'($urandom);
      i_b     = 4'($urandom);
    end
    i_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("ignored_valid_count", n_valid - n0, 1);

    // Error bit after divide-by-zero, then cleared by reset.
    run_op(2'd3, 4'b0101, 4'b0000, 4'b0000, 4'b1010, 1, "div0");
    run_op(2'd0, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 1, "add_after_err");
    do_reset();
    check("rst_clears_status", 32'(o_status), 32'(4'b0010));
    run_op(2'd0, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 1, "add_after_reset");

    // Reset on the second BUSY cycle of a divide.
    wait_ready("abort_div");
    i_valid = 1'b1;
    i_op    = 2'd3;
    i_a     = 4'b0111;
    i_b     = 4'b0010;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sticky_seen = 1'b0;
    n0 = n_valid;
    check("abort_ready", 32'(o_ready), 32'(1));
    check("abort_valid", 32'(o_valid), 32'(0));
    check("abort_result", 32'(o_result), 32'(0));
    check("abort_status", 32'(o_status), 32'(4'b0010));
    repeat (10) @(negedge clk);
    check("abort_no_stale_valid", n_valid - n0, 0);
    run_op(2'd0, 4'b0010, 4'b0011, 4'b0101, 4'b0000, 1, "add_after_abort");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
